seg_display_driver: RTL and testbench

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

---
 rtl/seg_display_driver_if.sv | 14 +
 rtl/seg_display_driver.sv | 210 +++++++++++++++++++++
 tb/tb_seg_display_driver.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg_display_driver_if.sv
// Display bus between the game controller and the 4-digit 7-segment driver.
// The controller (master) drives state and value; the driver (slave) drives
// the active-low segment, digit-enable and decimal-point lines.
interface seg_display_driver_if;
  logic [1:0]  select;  // 0 mode-select, 1 counting, 2 result, 3 target shown
  logic [1:0]  mode;    // 0 easy, 1 regular, 2 hard, 3 invalid
  logic [13:0] number;  // unsigned value to display
  logic [6:0]  seg;     // active-low {g,f,e,d,c,b,a}
  logic [3:0]  an;      // active-low digit enables, an[3] leftmost
  logic        dp;      // active-low decimal point

  modport master (output select, mode, number, input seg, an, dp);
  modport slave  (input select, mode, number, output seg, an, dp);
endinterface

// File: rtl/seg_display_driver.sv
// Four-digit multiplexed 7-segment driver.
// An iterative double-dabble converter turns the clamped input into four BCD
// digits that update atomically; a refresh counter scans digits 3..0 and the
// registered seg/an/dp lines follow the game state, with blinking in result.
module seg_display_driver #(
  parameter int unsigned REFRESH_TICKS = 100000,
  parameter int unsigned BLINK_FRAMES  = 125
) (
  input logic           clk,
  input logic           rst,
  seg_display_driver_if.slave bus
);

  localparam int RW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [13:0] MAX_VAL   = 14'd9999;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD} conv_state_e;

  // One shift-add-3 step: correct every BCD nibble >= 5, then shift in a bit.
  function automatic logic [15:0] dd_step(input logic [15:0] w, input logic b);
    logic [15:0] a;
    a = w;
    for (int i = 0; i < 4; i++) begin
      if (a[i*4 +: 4] >= 4'd5) a[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
    end
    return {a[14:0], b};
  endfunction

  function automatic logic [6:0] digit_pattern(input logic [3:0] d);
    case (d)
      4'd0:    digit_pattern = 7'h40;
      4'd1:    digit_pattern = 7'h79;
      4'd2:    digit_pattern = 7'h24;
      4'd3:    digit_pattern = 7'h30;
      4'd4:    digit_pattern = 7'h19;
      4'd5:    digit_pattern = 7'h12;
      4'd6:    digit_pattern = 7'h02;
      4'd7:    digit_pattern = 7'h78;
      4'd8:    digit_pattern = 7'h00;
      4'd9:    digit_pattern = 7'h10;
      default: digit_pattern = SEG_BLANK;
    endcase
  endfunction

  logic [13:0] clamped;
  assign clamped = (bus.number > MAX_VAL) ? MAX_VAL : bus.number;

  conv_state_e state_q, state_d;
  logic [13:0] last_q, last_d;
  logic [13:0] shreg_q, shreg_d;
  logic [15:0] work_q, work_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] bcd_q, bcd_d;

  // Converter state register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Converter next state: 14 shift cycles then one load cycle.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clamped != last_q) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == 4'd13)    state_d = S_LOAD;
      S_LOAD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Converter datapath: capture, shift, and atomic publish of the BCD result.
  always_comb begin
    last_d  = last_q;
    shreg_d = shreg_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    case (state_q)
      S_IDLE: begin
        if (clamped != last_q) begin
          last_d  = clamped;
          shreg_d = clamped;
          work_d  = '0;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        work_d  = dd_step(work_q, shreg_q[13]);
        shreg_d = {shreg_q[12:0], 1'b0};
        cnt_d   = cnt_q + 4'd1;
      end
      S_LOAD:  bcd_d = work_q;
      default: ;
    endcase
  end

  // Converter datapath registers.
  // NOTE: these are a handful of flops, not a memory, so all of them take the reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= '0;
      shreg_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      last_q  <= last_d;
      shreg_q <= shreg_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  logic [RW-1:0] refresh_q;
  logic [1:0]    digit_q;
  logic [FW-1:0] frame_q;
  logic          phase_q;
  logic          wrap;

  assign wrap = (refresh_q == RW'(REFRESH_TICKS - 1));

  // Refresh counter and digit scan 3->2->1->0->3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_q <= '0;
      digit_q   <= 2'd3;
    end else if (wrap) begin
      refresh_q <= '0;
      digit_q   <= digit_q - 2'd1;
    end else begin
      refresh_q <= refresh_q + RW'(1);
    end
  end

  // Blink timing: frames counted as the scan returns to digit 3; held on outside result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
      phase_q <= 1'b1;
    end else if (bus.select != 2'd2) begin
      frame_q <= '0;
      phase_q <= 1'b1;
    end else if (wrap && digit_q == 2'd0) begin
      if (frame_q == FW'(BLINK_FRAMES - 1)) begin
        frame_q <= '0;
        phase_q <= ~phase_q;
      end else begin
        frame_q <= frame_q + FW'(1);
      end
    end
  end

  logic [6:0] seg_d, seg_q;
  logic [3:0] an_d, an_q;
  logic       dp_d, dp_q;
  logic [3:0] nib;
  logic       shown;

  // Decode the digit about to be enabled for the current game state.
  always_comb begin
    nib   = bcd_q[{digit_q, 2'b00} +: 4];
    case (digit_q)
      2'd3:    shown = |bcd_q[15:12];
      2'd2:    shown = |bcd_q[15:8];
      2'd1:    shown = |bcd_q[15:4];
      default: shown = 1'b1;
    endcase
    an_d  = ~(4'b0001 << digit_q);
    seg_d = SEG_BLANK;
    dp_d  = ~(bus.select == 2'd1 && digit_q == 2'd0);
    if (bus.select == 2'd0) begin
      if (digit_q == 2'd3) begin
        case (bus.mode)
          2'd0:    seg_d = 7'h06;
          2'd1:    seg_d = 7'h2F;
          2'd2:    seg_d = 7'h09;
          default: seg_d = 7'h3F;
        endcase
      end
    end else if (bus.select == 2'd2 && !phase_q) begin
      an_d = 4'hF;
    end else if (shown) begin
      seg_d = digit_pattern(nib);
    end
  end

  // Output registers: seg, an and dp change together on each refresh wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= SEG_BLANK;
      an_q  <= 4'hF;
      dp_q  <= 1'b1;
    end else if (wrap) begin
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with a fast refresh (4 clocks per digit)
// and short blink (2 frames). Expected {an,seg,dp} words come from a small
// behavioural model, are queued when stimulus is applied, and are popped at
// each digit update of the DUT.
module tb_seg_display_driver;

  localparam int RT = 4;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_display_driver_if bus ();

  seg_display_driver #(.REFRESH_TICKS(RT), .BLINK_FRAMES(BF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [11:0] sb_q[$];
  int          m_frame = 0;
  bit          m_phase = 1'b1;
  logic [1:0]  cur_sel;
  logic [1:0]  cur_mode;
  int          cur_val;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected {an,seg,dp} when digit 'digit' is enabled.
  function automatic logic [11:0] model(input int digit, input logic [1:0] sel,
                                        input logic [1:0] md, input int num, input bit ph);
    int         v;
    int         dv;
    bit         shown;
    logic [3:0] a;
    logic [6:0] s;
    logic       p;
    v  = (num > 9999) ? 9999 : num;
    a  = 4'hF;
    a[digit] = 1'b0;
    s  = 7'h7F;
    p  = !(sel == 2'd1 && digit == 0);
    case (digit)
      0: dv = v % 10;
      1: dv = (v / 10) % 10;
      2: dv = (v / 100) % 10;
      default: dv = v / 1000;
    endcase
    shown = (digit == 0) || (digit == 1 && v >= 10) || (digit == 2 && v >= 100) ||
            (digit == 3 && v >= 1000);
    if (sel == 2'd0) begin
      if (digit == 3) s = (md == 2'd0) ? 7'h06 : (md == 2'd1) ? 7'h2F : (md == 2'd2) ? 7'h09 : 7'h3F;
    end else if (sel == 2'd2 && !ph) begin
      a = 4'hF;
    end else if (shown) begin
      s = pat(dv);
    end
    return {a, s, p};
  endfunction

  task automatic drive(input logic [1:0] sel, input logic [1:0] md, input int num);
    bus.select = sel;
    bus.mode   = md;
    bus.number = 14'(num);
    cur_sel    = sel;
    cur_mode   = md;
    cur_val    = num;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance to just after the next refresh wrap (at most RT clocks).
  task automatic wait_update();
    do tick(); while (cyc % RT != 0);
  endtask

  // Queue n expected digit updates from the model, then compare them in order.
  task automatic expect_updates(input int n, input string tag);
    logic [11:0] e;
    for (int i = 0; i < n; i++) begin
      int k;
      int digit;
      k     = cyc / RT + 1 + i;
      digit = 3 - ((k - 1) % 4);
      sb_q.push_back(model(digit, cur_sel, cur_mode, cur_val, m_phase));
      if (cur_sel != 2'd2) begin
        m_frame = 0;
        m_phase = 1'b1;
      end else if (digit == 0) begin
        if (m_frame == BF - 1) begin
          m_frame = 0;
          m_phase = !m_phase;
        end else begin
          m_frame++;
        end
      end
    end
    for (int i = 0; i < n; i++) begin
      wait_update();
      e = sb_q.pop_front();
      check(tag, 16'({bus.an, bus.seg, bus.dp}), 16'(e));
    end
  endtask

  initial begin
    int st;
    int ns;
    int digit;
    bit seen_one;

    rst = 1'b1;
    drive(2'd1, 2'd0, 0);
    @(negedge clk);
    @(negedge clk);
    check("rst_seg", 16'(bus.seg), 16'h7F);
    check("rst_an",  16'(bus.an),  16'hF);
    check("rst_dp",  16'(bus.dp),  16'h1);

    // Release and confirm no digit is enabled until the first refresh wrap.
    rst = 1'b0;
    cyc = 0;
    ticks(3);
    check("pre_wrap_an", 16'(bus.an), 16'hF);
    expect_updates(1, "first_wrap");

    // Counting state, 1234 with dp on digit 0.
    drive(2'd1, 2'd0, 1234);
    ticks(20);
    expect_updates(8, "count_1234");

    // Clamp above 9999, then leading-zero blanking.
    drive(2'd3, 2'd0, 12000);
    ticks(20);
    expect_updates(4, "clamp_9999");
    drive(2'd3, 2'd0, 7);
    ticks(20);
    expect_updates(4, "blank_7");

    // Mode-select letters.
    for (int m = 0; m < 4; m++) begin
      drive(2'd0, 2'(m), 7);
      expect_updates(4, "mode_sel");
    end

    // 100 then 200 mid-conversion: digit 2 may only go blank -> '1' -> '2'.
    drive(2'd1, 2'd0, 100);
    ticks(5);
    drive(2'd1, 2'd0, 200);
    st = 0;
    seen_one = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wait_update();
      digit = 3 - ((cyc / RT - 1) % 4);
      if (digit == 2) begin
        ns = (bus.seg == 7'h7F) ? 0 : (bus.seg == 7'h79) ? 1 : (bus.seg == 7'h24) ? 2 : 3;
        check("no_partial_d2", 16'((ns != 3) && (ns >= st)), 16'h1);
        if (ns != 3 && ns >= st) st = ns;
        if (ns == 1) seen_one = 1'b1;
      end
    end
    check("saw_100", 16'(seen_one), 16'h1);
    check("end_200", 16'(st), 16'h2);
    expect_updates(4, "after_200");

    // Result-state blinking, starting on a frame boundary.
    drive(2'd1, 2'd0, 45);
    ticks(20);
    while (cyc % (4 * RT) != 0) tick();
    drive(2'd2, 2'd0, 45);
    expect_updates(12, "blink");
    drive(2'd1, 2'd0, 45);
    expect_updates(1, "blink_exit");
    drive(2'd2, 2'd0, 45);
    expect_updates(8, "blink_reentry");

    // Asynchronous reset in the middle of a 9999 conversion.
    drive(2'd3, 2'd0, 9999);
    ticks(5);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_seg", 16'(bus.seg), 16'h7F);
    check("mid_rst_an",  16'(bus.an),  16'hF);
    check("mid_rst_dp",  16'(bus.dp),  16'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    ticks(20);
    expect_updates(4, "reconvert_9999");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
